// File: rtl/nand_serial_arbiter.sv
// Round-robin arbiter that time-shares one NAND cell among NREQ requesters,
// pushing each winner's operands through it LSB first and returning the result.

module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// state  | meaning
// idle   | waiting for a request; grant is combinational from rr_ptr
// shift  | one operand bit pair through the cell per cycle, WIDTH cycles
// done   | result presented on rsp_*; held until the consumer accepts
module nand_serial_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
);

  localparam int idw = $clog2(NREQ);
  localparam int cw  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [cw-1:0] cnt_last = cw'(WIDTH - 1);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_shift = 2'd1;
  localparam logic [1:0] st_done  = 2'd2;

  logic [1:0]       state;
  logic [idw-1:0]   rr_ptr;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [cw-1:0]    cnt;
  logic [idw-1:0]   id_q;

  logic [NREQ-1:0]  grant;
  logic [idw-1:0]   gnt_idx;
  logic             found;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [idw-1:0]   scan_idx;
  int               scan_pos;
  logic             accept;
  logic             cell_y;
  logic [WIDTH-1:0] y_msb;
  logic [idw-1:0]   rr_next;

  // Scan starts at rr_ptr and wraps, so the last winner becomes lowest priority.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    sel_a    = '0;
    sel_b    = '0;
    scan_idx = '0;
    scan_pos = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan_pos = (int'(rr_ptr) + i) % NREQ;
      scan_idx = idw'(scan_pos);
      if (!found && req_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        gnt_idx         = scan_idx;
        sel_a           = req_a[scan_pos*WIDTH +: WIDTH];
        sel_b           = req_b[scan_pos*WIDTH +: WIDTH];
      end
    end
  end

  assign accept    = (state == st_idle) && found;
  assign req_ready = ((state == st_idle) && rst_n) ? grant : '0;
  assign rr_next   = (gnt_idx == idw'(NREQ - 1)) ? '0 : gnt_idx + idw'(1);

  nand_gate u_cell (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .y (cell_y)
  );

  always_comb begin
    y_msb            = '0;
    y_msb[WIDTH-1]   = cell_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= st_idle;
      rr_ptr <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      cnt    <= '0;
      id_q   <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (accept) begin
            a_sr   <= sel_a;
            b_sr   <= sel_b;
            id_q   <= gnt_idx;
            rr_ptr <= rr_next;
            cnt    <= '0;
            state  <= st_shift;
          end
        end
        st_shift: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= (res >> 1) | y_msb;
          if (cnt == cnt_last) begin
            state <= st_done;
          end else begin
            cnt <= cnt + cw'(1);
          end
        end
        st_done: begin
          if (rsp_ready) begin
            state <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign rsp_valid = (state == st_done);
  assign rsp_id    = id_q;
  assign rsp_data  = res;
  assign busy      = (state != st_idle);

endmodule

// File: tb/tb_nand_serial_arbiter.sv
// Self-checking bench for nand_serial_arbiter: directed scenarios plus random
// traffic, all checked every cycle against a transaction-level reference model.

module tb_nand_serial_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;

  nand_serial_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int tick  = 0;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one operation in flight, result due WIDTH edges after
  // the accept edge, retired by the first edge that sees rsp_ready.
  logic             m_busy  = 1'b0;
  logic             m_valid = 1'b0;
  int               m_left  = 0;
  int               m_rr    = 0;
  int               m_id    = 0;
  logic [WIDTH-1:0] m_data  = '0;
  int               grants[$];
  int               acc_t[$];

  function automatic int scan(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = scan(m_rr, req_valid);
    if (rst_n && !m_busy && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_rr    <= 0;
      m_id    <= 0;
      m_data  <= '0;
    end else if (!m_busy) begin
      if (scan(m_rr, req_valid) >= 0) begin
        m_busy <= 1'b1;
        m_left <= WIDTH;
        m_id   <= scan(m_rr, req_valid);
        m_data <= ~(req_a[scan(m_rr, req_valid)*WIDTH +: WIDTH] &
                    req_b[scan(m_rr, req_valid)*WIDTH +: WIDTH]);
        m_rr   <= (scan(m_rr, req_valid) + 1) % NREQ;
        grants.push_back(scan(m_rr, req_valid));
        acc_t.push_back(tick);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_valid <= 1'b1;
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, exp_ready());
    chk("busy", busy, m_busy);
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_data);
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]             = v;
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) ok = 1'b1;
    end
    chk("rsp_timeout", ok, 1'b1);
  endtask

  task automatic single_op(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp, input string nm);
    logic ok;
    set_req(i, 1'b1, a, b);
    tick1();
    req_valid[i] = 1'b0;
    wait_rsp(ok);
    if (ok) begin
      chk({nm, "_id"}, rsp_id, i);
      chk({nm, "_data"}, rsp_data, exp);
      chk({nm, "_latency"}, tick - acc_t[$], WIDTH + 1);
      chk({nm, "_grant"}, grants[$], i);
    end
    tick1();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && m_busy; k++) tick1();
    chk("drain_idle", m_busy, 1'b0);
  endtask

  task automatic wait_grants(input int target);
    for (int k = 0; k < 120 && grants.size() < target; k++) tick1();
    chk("grant_count", grants.size() >= target, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    int   seen;
    logic ok;

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_req_ready", req_ready, 4'b0000);
    req_valid = '0;
    rst_n = 1'b1;
    tick1();

    // basic and truth table
    single_op(2, 8'hF0, 8'hCC, 8'h3F, "t1");
    single_op(0, 8'h00, 8'h00, 8'hFF, "t2a");
    single_op(1, 8'hFF, 8'hFF, 8'h00, "t2b");
    single_op(3, 8'hAA, 8'h55, 8'hFF, "t2c");
    single_op(2, 8'hFF, 8'h0F, 8'hF0, "t2d");

    // round-robin from rr_ptr=0 with all requesters held
    rst_n = 1'b0;
    tick1();
    rst_n = 1'b1;
    tick1();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'($urandom), 8'($urandom));
    n0 = grants.size();
    wait_grants(n0 + 5);
    req_valid = '0;
    if (grants.size() >= n0 + 5) begin
      for (int k = 0; k < 5; k++) chk("t3_order", grants[n0 + k], k % NREQ);
      for (int k = 1; k < 5; k++) chk("t3_interval", acc_t[n0 + k] - acc_t[n0 + k - 1], WIDTH + 2);
    end
    drain();

    // fairness: requesters 1 and 3 held, rr_ptr brought to 2
    single_op(1, 8'h0F, 8'h33, 8'hFC, "t4pre");
    set_req(1, 1'b1, 8'h11, 8'h22);
    set_req(3, 1'b1, 8'h44, 8'h88);
    n0 = grants.size();
    wait_grants(n0 + 4);
    req_valid = '0;
    if (grants.size() >= n0 + 4) begin
      chk("t4_g0", grants[n0], 3);
      chk("t4_g1", grants[n0 + 1], 1);
      chk("t4_g2", grants[n0 + 2], 3);
      chk("t4_g3", grants[n0 + 3], 1);
    end
    drain();

    // backpressure
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 8'h3C, 8'h0F);
    tick1();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 8'h5A, 8'hF0);
    wait_rsp(ok);
    for (int k = 0; k < 5; k++) begin
      chk("t5_valid", rsp_valid, 1'b1);
      chk("t5_id", rsp_id, 0);
      chk("t5_data", rsp_data, 8'hF3);
      chk("t5_ready", req_ready, 4'b0000);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_still_valid", rsp_valid, 1'b1);
    @(negedge clk);
    chk("t5_idle", busy, 1'b0);
    chk("t5_regrant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(ok);
    chk("t5_next_data", rsp_data, 8'hAF);
    tick1();

    // reset in the middle of SHIFT
    set_req(2, 1'b1, 8'hC3, 8'h7E);
    tick1();
    req_valid = '0;
    repeat (4) tick1();
    req_valid = '1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    chk("t6_rsp_id", rsp_id, 0);
    chk("t6_rsp_data", rsp_data, 8'h00);
    chk("t6_req_ready", req_ready, 4'b0000);
    req_valid = '0;
    tick1();
    tick1();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    chk("t6_no_rsp", seen, 0);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 8'h12, 8'h34);
    set_req(1, 1'b1, 8'h00, 8'h00);
    set_req(2, 1'b1, 8'h00, 8'h00);
    set_req(3, 1'b1, 8'h00, 8'h00);
    tick1();
    req_valid = '0;
    chk("t6_rr_reset", grants[$], 0);
    wait_rsp(ok);
    chk("t6_data", rsp_data, 8'hEF);
    chk("t6_id", rsp_id, 0);
    tick1();
    single_op(3, 8'hA5, 8'h3C, 8'hDB, "t6_fresh");

    // random traffic
    for (int c = 0; c < 500; c++) begin
      req_valid = NREQ'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick1();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();
    repeat (3) tick1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
